pwm_fade_ctrl: RTL and testbench

PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

---
 rtl/pwm_fade_pkg.sv | 14 +
 rtl/pwm_core.sv | 28 ++
 rtl/pwm_fade_ctrl.sv | 123 ++++++++++++
 tb/tb_pwm_fade_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_fade_pkg.sv
// Shared state type and constants for the PWM fade controller.
package pwm_fade_pkg;

  localparam int DUTY_W_DEF = 8;

  // Wide all-ones pattern; users slice it down to their counter width.
  localparam logic [31:0] PERIOD_ONES = '1;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } fade_state_t;

endpackage

// File: rtl/pwm_core.sv
// Free-running period counter and registered duty comparator.
module pwm_core
  import pwm_fade_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DUTY_W-1:0] duty,
  output logic              pout,
  output logic              period_end
);

  logic [DUTY_W-1:0] pcnt;

  assign period_end = (pcnt == PERIOD_ONES[DUTY_W-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
      pout <= 1'b0;
    end else begin
      pcnt <= pcnt + 1'b1;
      pout <= (pcnt < duty);
    end
  end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// PWM fade controller: ramps the duty toward a target, one step per dwell interval.
// Optional sticky completion flag enabled by defining PWM_FADE_DONE_IRQ_EN.
module pwm_fade_ctrl
  import pwm_fade_pkg::*;
#(
  parameter int DUTY_W  = DUTY_W_DEF,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [DUTY_W-1:0]  tgt_duty,
  input  logic [DUTY_W-1:0]  step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               abort,
  input  logic               irq_clr,
  output logic [DUTY_W-1:0]  duty,
  output logic               pout,
  output logic               busy,
  output logic               done,
  output logic               done_irq
);

  fade_state_t        state, state_nxt;
  logic [DUTY_W-1:0]  tgt_q, step_q, duty_nxt;
  logic [DWELL_W-1:0] dwell_q, dwell_cnt, dwell_cnt_nxt;
  logic [DUTY_W:0]    diff, delta, stepped;
  logic               done_nxt, period_end, accept, rising;

  assign cmd_ready = (state == IDLE) && !abort;
  assign busy      = (state == RAMP);
  assign accept    = cmd_valid && cmd_ready;

  pwm_core #(.DUTY_W(DUTY_W)) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .duty       (duty),
    .pout       (pout),
    .period_end (period_end)
  );

  // One extra bit keeps the step from wrapping; delta is clamped to the remaining distance.
  always_comb begin
    rising  = (tgt_q >= duty);
    diff    = rising ? ({1'b0, tgt_q} - {1'b0, duty}) : ({1'b0, duty} - {1'b0, tgt_q});
    delta   = ({1'b0, step_q} < diff) ? {1'b0, step_q} : diff;
    stepped = rising ? ({1'b0, duty} + delta) : ({1'b0, duty} - delta);
  end

  always_comb begin
    state_nxt     = state;
    duty_nxt      = duty;
    dwell_cnt_nxt = dwell_cnt;
    done_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          dwell_cnt_nxt = dwell;
          if (tgt_duty == duty) done_nxt  = 1'b1;
          else                  state_nxt = RAMP;
        end
      end
      RAMP: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (period_end) begin
          if (dwell_cnt != '0) begin
            dwell_cnt_nxt = dwell_cnt - 1'b1;
          end else begin
            duty_nxt      = stepped[DUTY_W-1:0];
            dwell_cnt_nxt = dwell_q;
            if (stepped == {1'b0, tgt_q}) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      duty      <= '0;
      dwell_cnt <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      duty      <= duty_nxt;
      dwell_cnt <= dwell_cnt_nxt;
      done      <= done_nxt;
    end
  end

  // Command fields are captured only on acceptance; a zero step behaves as one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_q   <= '0;
      step_q  <= '0;
      dwell_q <= '0;
    end else if (accept) begin
      tgt_q   <= tgt_duty;
      step_q  <= (step == '0) ? DUTY_W'(1) : step;
      dwell_q <= dwell;
    end
  end

`ifdef PWM_FADE_DONE_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       done_irq <= 1'b0;
    else if (done)    done_irq <= 1'b1;
    else if (irq_clr) done_irq <= 1'b0;
  end
`else
  logic unused_irq_clr;
  assign unused_irq_clr = irq_clr;
  assign done_irq       = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Self-checking bench for pwm_fade_ctrl against a ramp-plan reference model.
module tb_pwm_fade_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, abort, irq_clr;
  logic [7:0] tgt_duty, step, dwell;
  logic [7:0] duty;
  logic       cmd_ready, pout, busy, done, done_irq;

  int checks = 0;
  int errors = 0;
  int mdlDuty = 0;
  int plan[$];

`ifdef PWM_FADE_DONE_IRQ_EN
  localparam int IRQ_EXP = 1;
`else
  localparam int IRQ_EXP = 0;
`endif

  always #5 clk = ~clk;

  pwm_fade_ctrl #(.DUTY_W(8), .DWELL_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .tgt_duty  (tgt_duty),
    .step      (step),
    .dwell     (dwell),
    .abort     (abort),
    .irq_clr   (irq_clr),
    .duty      (duty),
    .pout      (pout),
    .busy      (busy),
    .done      (done),
    .done_irq  (done_irq)
  );

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sequence of duty values a ramp should visit, from plain distance arithmetic.
  function automatic void buildPlan(input int from, input int to, input int stp);
    int d = from;
    plan.delete();
    while (d != to) begin
      if (to > d) d += ((to - d) < stp) ? (to - d) : stp;
      else        d -= ((d - to) < stp) ? (d - to) : stp;
      plan.push_back(d);
    end
  endfunction

  task automatic issueCmd(input int tgt, input int stp, input int dw);
    @(negedge clk);
    tgt_duty  = 8'(tgt);
    step      = 8'(stp);
    dwell     = 8'(dw);
    cmd_valid = 1'b1;
    #1 checkOutput("cmd_ready_idle", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic applyStimulus(input int tgt, input int stp, input int dw);
    int seen[$];
    int changeCyc[$];
    int cyc, doneCnt, prev, limit, highs, period;
    bit finished;
    period = 256 * (dw + 1);
    buildPlan(mdlDuty, tgt, (stp == 0) ? 1 : stp);
    issueCmd(tgt, stp, dw);
    if (plan.size() == 0) begin
      checkOutput("equal_done", done, 1);
      checkOutput("equal_busy", busy, 0);
      @(negedge clk);
      checkOutput("equal_done_once", done, 0);
      checkOutput("equal_busy_after", busy, 0);
      checkOutput("equal_irq", done_irq, IRQ_EXP);
      return;
    end
    checkOutput("busy_after_accept", busy, 1);
    prev = duty; cyc = 0; doneCnt = 0; finished = 1'b0;
    limit = (plan.size() + 1) * period + 16;
    while (!finished && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (duty != 8'(prev)) begin
        seen.push_back(duty);
        changeCyc.push_back(cyc);
        prev = duty;
      end
      if (done) begin
        doneCnt++;
        checkOutput("done_at_target", duty, tgt);
        checkOutput("busy_low_at_done", busy, 0);
      end
      if (!busy) finished = 1'b1;
    end
    checkOutput("ramp_completed", finished, 1);
    checkOutput("step_count", seen.size(), plan.size());
    for (int i = 0; i < seen.size() && i < plan.size(); i++)
      checkOutput($sformatf("step_value_%0d", i), seen[i], plan[i]);
    if (changeCyc.size() > 0)
      checkOutput("first_step_latency", (changeCyc[0] >= 1 && changeCyc[0] <= period), 1);
    for (int i = 1; i < changeCyc.size(); i++)
      checkOutput($sformatf("step_interval_%0d", i), changeCyc[i] - changeCyc[i-1], period);
    checkOutput("done_count", doneCnt, 1);
    @(negedge clk);
    checkOutput("done_one_cycle", done, 0);
    mdlDuty = tgt;
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (pout) highs++;
    end
    checkOutput("pout_high_time", highs, tgt);
  endtask

  initial begin
    int cyc, dc, tg, st, dw, changes;
    rst_n = 1'b0; cmd_valid = 1'b0; abort = 1'b0; irq_clr = 1'b0;
    tgt_duty = '0; step = '0; dwell = '0;
    #1;
    checkOutput("rst_duty", duty, 0);
    checkOutput("rst_pout", pout, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_irq", done_irq, 0);
    checkOutput("rst_ready", cmd_ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] ramp up 0 -> 128 step 16");
    applyStimulus(128, 16, 0);
    $display("[TB] ramp down 128 -> 0 step 50 dwell 1");
    applyStimulus(0, 50, 1);
    $display("[TB] zero step 0 -> 3");
    applyStimulus(3, 0, 0);

    $display("[TB] target equal to current duty");
    @(negedge clk); irq_clr = 1'b1;
    @(negedge clk); irq_clr = 1'b0;
    checkOutput("irq_cleared_before", done_irq, 0);
    applyStimulus(3, 7, 2);
    @(negedge clk); irq_clr = 1'b1;
    @(negedge clk); irq_clr = 1'b0;
    checkOutput("irq_cleared_after", done_irq, 0);

    $display("[TB] abort at duty 48");
    issueCmd(128, 15, 0);
    cyc = 0;
    while (duty != 8'd48 && cyc < 4 * 256 + 16) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("abort_reach_48", duty, 48);
    abort = 1'b1;
    #1 checkOutput("abort_busy_before", busy, 1);
    @(negedge clk);
    checkOutput("abort_idle", busy, 0);
    checkOutput("abort_duty_frozen", duty, 48);
    checkOutput("abort_no_done", done, 0);
    checkOutput("abort_blocks_ready", cmd_ready, 0);
    cmd_valid = 1'b1; tgt_duty = 8'd200;
    @(negedge clk);
    checkOutput("abort_no_accept", busy, 0);
    cmd_valid = 1'b0; abort = 1'b0;
    #1 checkOutput("ready_after_abort", cmd_ready, 1);
    dc = 0; changes = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) dc++;
      if (duty != 8'd48) changes++;
    end
    checkOutput("abort_quiet_done", dc, 0);
    checkOutput("abort_quiet_duty", changes, 0);
    mdlDuty = 48;

    $display("[TB] randomized ramps");
    for (int n = 0; n < 4; n++) begin
      tg = $urandom_range(0, 255);
      st = $urandom_range(24, 96);
      dw = $urandom_range(0, 1);
      applyStimulus(tg, st, dw);
    end

    $display("[TB] reset mid-ramp");
    tg = (mdlDuty < 128) ? 255 : 0;
    issueCmd(tg, 5, 0);
    changes = 0; cyc = 0; dc = duty;
    while (changes < 2 && cyc < 3 * 256 + 16) begin
      @(negedge clk);
      cyc++;
      if (duty != 8'(dc)) begin changes++; dc = duty; end
    end
    checkOutput("midramp_progress", changes, 2);
    checkOutput("midramp_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_duty", duty, 0);
    checkOutput("midrst_pout", pout, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_ready", cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    mdlDuty = 0;
    applyStimulus(64, 32, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
